// File: rtl/sym_deframer.sv
// sym_deframer: hunts for a sync word in a serial bit stream, then slices framed W-bit data symbols
module sym_deframer #(
    parameter int             W          = 3,
    parameter logic [W-1:0]   SYNC       = 3'b101,
    parameter int             FRAME_SYMS = 4,
    parameter int             MAX_MISS   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic [W-1:0] sym,
    output logic         sym_valid,
    output logic         locked,
    output logic         sync_err
);
    localparam int BW = $clog2(W);
    localparam int SW = $clog2(FRAME_SYMS + 1);
    localparam int MW = $clog2(MAX_MISS + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(W - 1);
    localparam logic [SW-1:0] LAST_SYM  = SW'(FRAME_SYMS - 1);
    localparam logic [MW-1:0] LAST_MISS = MW'(MAX_MISS - 1);

    typedef enum logic [1:0] {HUNT, DATA, SYNC_CHK} state_t;

    state_t        r_state, w_state;
    logic [W-2:0]  r_sh, w_sh;
    logic [BW-1:0] r_fill, w_fill, r_bit, w_bit;
    logic [SW-1:0] r_syms, w_syms;
    logic [MW-1:0] r_miss, w_miss;
    logic [W-1:0]  r_sym, w_sym;
    logic          r_sym_valid, w_sym_valid, r_locked, w_locked, r_sync_err, w_sync_err;
    logic [W-1:0]  w_win;

    assign w_win     = {r_sh, bit_in};
    assign sym       = r_sym;
    assign sym_valid = r_sym_valid;
    assign locked    = r_locked;
    assign sync_err  = r_sync_err;

    // next-state and datapath: nothing moves unless a bit is presented, pulses default low
    always_comb begin
        w_state     = r_state;
        w_sh        = r_sh;
        w_fill      = r_fill;
        w_bit       = r_bit;
        w_syms      = r_syms;
        w_miss      = r_miss;
        w_sym       = r_sym;
        w_locked    = r_locked;
        w_sym_valid = 1'b0;
        w_sync_err  = 1'b0;
        if (bit_valid) begin
            w_sh = w_win[W-2:0];
            case (r_state)
                HUNT: begin
                    w_fill = (r_fill == LAST_BIT) ? r_fill : r_fill + 1'b1;
                    if (w_win == SYNC && r_fill == LAST_BIT) begin
                        w_state  = DATA;
                        w_locked = 1'b1;
                        w_bit    = '0;
                        w_syms   = '0;
                        w_miss   = '0;
                    end
                end
                DATA: begin
                    w_bit = (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
                    if (r_bit == LAST_BIT) begin
                        w_sym       = w_win;
                        w_sym_valid = 1'b1;
                        w_syms      = r_syms + 1'b1;
                        w_state     = (r_syms == LAST_SYM) ? SYNC_CHK : DATA;
                    end
                end
                SYNC_CHK: begin
                    w_bit = (r_bit == LAST_BIT) ? '0 : r_bit + 1'b1;
                    if (r_bit == LAST_BIT) begin
                        w_syms = '0;
                        if (w_win == SYNC) begin
                            w_miss  = '0;
                            w_state = DATA;
                        end else begin
                            w_sync_err = 1'b1;
                            w_miss     = r_miss + 1'b1;
                            if (r_miss == LAST_MISS) begin
                                w_state  = HUNT;
                                w_locked = 1'b0;
                                w_fill   = '0;
                            end else begin
                                w_state = DATA;
                            end
                        end
                    end
                end
                default: w_state = HUNT;
            endcase
        end
    end

    // state and output registers, cleared immediately by the active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= HUNT;
            r_sh        <= '0;
            r_fill      <= '0;
            r_bit       <= '0;
            r_syms      <= '0;
            r_miss      <= '0;
            r_sym       <= '0;
            r_sym_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sh        <= w_sh;
            r_fill      <= w_fill;
            r_bit       <= w_bit;
            r_syms      <= w_syms;
            r_miss      <= w_miss;
            r_sym       <= w_sym;
            r_sym_valid <= w_sym_valid;
            r_locked    <= w_locked;
            r_sync_err  <= w_sync_err;
        end
    end
endmodule

// File: tb/tb_sym_deframer.sv
// tb_sym_deframer: directed stimulus with a queue-based scoreboard for sym_deframer
module tb_sym_deframer;
    localparam int W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, bit_in, bit_valid, b0_in, b0_valid;
    logic [W-1:0] sym, sym0;
    logic         sym_valid, locked, sync_err, sv0, lk0, se0;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_sym_q[$];
    int           exp_err_q[$];
    logic [W-1:0] last_sym;
    int           gap;
    logic         prev_sv = 1'b0;

    sym_deframer u_dut (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .sym(sym), .sym_valid(sym_valid), .locked(locked), .sync_err(sync_err)
    );

    sym_deframer #(.SYNC(3'b000)) u_dut0 (
        .clk(clk), .rst(rst), .bit_in(b0_in), .bit_valid(b0_valid),
        .sym(sym0), .sym_valid(sv0), .locked(lk0), .sync_err(se0)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: pops expected symbols / sync errors whenever the DUT strobes
    always @(negedge clk) begin
        if (sym_valid) begin
            chk("sym_valid_width", int'(prev_sv), 0);
            if (exp_sym_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sym_unexpected: got pulse with sym=%0d expected no pulse", sym);
            end else begin
                chk("sym", int'(sym), int'(exp_sym_q.pop_front()));
            end
        end
        if (sync_err) begin
            if (exp_err_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sync_err_unexpected: got pulse expected none");
            end else begin
                chk("sync_err", int'(sync_err), exp_err_q.pop_front());
            end
        end
        prev_sv = sym_valid;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bit_valid = 1'b0;
        bit_in = ~bit_in;
        @(posedge clk); #1;
        chk("idle_sym", int'(sym), int'(last_sym));
        chk("idle_sym_valid", int'(sym_valid), 0);
        chk("idle_sync_err", int'(sync_err), 0);
    endtask

    task automatic send_bit(input logic b);
        bit_in = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        if (gap != 0) idle();
    endtask

    task automatic send_sym(input logic [W-1:0] v, input bit data, input bit err);
        if (data) exp_sym_q.push_back(v);
        if (err) exp_err_q.push_back(1);
        for (int i = 0; i < W; i++) begin
            bit_in = v[W-1-i];
            bit_valid = 1'b1;
            @(posedge clk); #1;
            bit_valid = 1'b0;
            if (i == W - 1 && data) last_sym = v;
            if (gap != 0) idle();
        end
    endtask

    initial begin
        logic [9:0] hunt_bits;
        rst = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; b0_in = 1'b0; b0_valid = 1'b0;
        gap = 0; last_sym = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_sym", int'(sym), 0);
        chk("rst_sym_valid", int'(sym_valid), 0);
        chk("rst_sync_err", int'(sync_err), 0);
        chk("rst_locked0", int'(lk0), 0);
        rst = 1'b1;

        send_bit(1'b0); chk("t1_locked_b1", int'(locked), 0);
        send_bit(1'b0); chk("t1_locked_b2", int'(locked), 0);
        send_bit(1'b1); chk("t1_locked_b3", int'(locked), 0);
        send_bit(1'b0); chk("t1_locked_b4", int'(locked), 0);
        send_bit(1'b1); chk("t1_locked_b5", int'(locked), 1);

        send_sym(3'b011, 1, 0);
        send_sym(3'b100, 1, 0);
        send_sym(3'b111, 1, 0);
        send_sym(3'b000, 1, 0);
        send_sym(3'b101, 0, 0);
        chk("t2_locked", int'(locked), 1);
        chk("t2_sym_hold", int'(sym), 0);

        send_sym(3'b001, 1, 0);
        send_sym(3'b010, 1, 0);
        send_sym(3'b011, 1, 0);
        send_sym(3'b110, 1, 0);
        send_sym(3'b110, 0, 1);
        chk("t3_locked_miss1", int'(locked), 1);
        send_sym(3'b010, 1, 0);
        send_sym(3'b100, 1, 0);
        send_sym(3'b001, 1, 0);
        send_sym(3'b111, 1, 0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("t3_locked_mid_sync", int'(locked), 1);
        exp_err_q.push_back(1);
        send_bit(1'b1);
        chk("t3_locked_drop", int'(locked), 0);
        hunt_bits = 10'b0001100101;
        for (int i = 9; i >= 1; i--) begin
            send_bit(hunt_bits[i]);
            chk("t3_hunt_locked", int'(locked), 0);
        end
        send_bit(hunt_bits[0]);
        chk("t3_relock", int'(locked), 1);

        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        last_sym = '0;
        gap = 1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t4_locked", int'(locked), 1);
        send_sym(3'b011, 1, 0);
        send_sym(3'b100, 1, 0);
        send_sym(3'b111, 1, 0);
        send_sym(3'b000, 1, 0);
        send_sym(3'b101, 0, 0);
        chk("t4_locked_end", int'(locked), 1);
        chk("t4_sym_hold", int'(sym), 0);
        gap = 0;

        send_sym(3'b110, 1, 0);
        chk("t5_sym_before", int'(sym), 6);
        send_bit(1'b1);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_locked", int'(locked), 0);
        chk("t5_async_sym", int'(sym), 0);
        chk("t5_async_sym_valid", int'(sym_valid), 0);
        chk("t5_async_sync_err", int'(sync_err), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        last_sym = '0;
        send_bit(1'b1); chk("t5_locked_1", int'(locked), 0);
        send_bit(1'b1); chk("t5_locked_2", int'(locked), 0);
        send_bit(1'b0); chk("t5_locked_3", int'(locked), 0);
        send_bit(1'b1); chk("t5_locked_4", int'(locked), 1);

        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        b0_in = 1'b0;
        b0_valid = 1'b1;
        @(posedge clk); #1;
        chk("t6_locked_b1", int'(lk0), 0);
        @(posedge clk); #1;
        chk("t6_locked_b2", int'(lk0), 0);
        @(posedge clk); #1;
        chk("t6_locked_b3", int'(lk0), 1);
        b0_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("sym_queue_drained", exp_sym_q.size(), 0);
        chk("err_queue_drained", exp_err_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sym_deframer.md
Name: sym_deframer

Overview:
- Upstream stage of the 3-bit symbol detector. It takes a serial bit stream and hunts for a sync word.
- Once locked, it slices the stream into W-bit symbols and presents each data symbol with a one-cycle valid strobe. These symbols drive the detector's `inp` bus.
- It re-checks the sync word at the end of every frame and drops lock after MAX_MISS consecutive bad syncs.

Parameters:
- W, 3, symbol width in bits; must be >= 2.
- SYNC, 3'b101, sync word, W bits, MSB received first.
- FRAME_SYMS, 4, number of data symbols between sync words; must be >= 1.
- MAX_MISS, 2, number of consecutive bad syncs that forces return to HUNT; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bit_in  in  1  serial data bit, MSB of each symbol first.
- bit_valid  in  1  bit_in is sampled on a rising clk edge only when this is 1.
- sym  out  W  last emitted data symbol; holds its value between strobes.
- sym_valid  out  1  one-cycle pulse; sym is new this cycle.
- locked  out  1  high while in DATA or SYNC_CHK.
- sync_err  out  1  one-cycle pulse on each bad sync word.

Behaviour:
- Reset (rst=0): applied immediately, no clock needed.
  - state=HUNT; sym, sym_valid, locked, sync_err all 0.
  - Internal shift register, fill count, bit count, symbol count and miss count all 0.
- Definitions:
  - Valid edge: a rising clk edge with bit_valid=1. On every valid edge sh <= {sh[W-2:0], bit_in}.
  - win = {sh[W-2:0], bit_in}, evaluated combinationally at that edge.
  - No state or counter changes on edges with bit_valid=0.
- sym_valid and sync_err default to 0 on every edge, so each is a single-cycle pulse. Both are registered: they go high in the cycle after the edge that sampled the last bit of the group.
- HUNT:
  - fill counts valid bits and saturates at W-1.
  - When win==SYNC and fill==W-1 on a valid edge: go to DATA, set locked=1, clear bit count, symbol count and miss count.
  - The fill check prevents reset zeros from matching a SYNC of all zeros.
- DATA:
  - Bit count runs 0..W-1. On the valid edge carrying bit W-1: sym<=win, sym_valid<=1, symbol count increments, bit count wraps to 0.
  - When the symbol count reaches FRAME_SYMS (after the last data symbol is emitted): go to SYNC_CHK.
- SYNC_CHK:
  - Collect W bits; no sym_valid is produced for the sync group.
  - If win==SYNC on bit W-1: miss<=0, go to DATA, symbol count<=0.
  - Otherwise, sync_err<=1 and miss increments:
    - If miss+1==MAX_MISS: go to HUNT, locked<=0, fill<=0. The last W-1 bits are not reused.
    - Otherwise: go to DATA, symbol count<=0, locked stays 1. Free-wheel on the assumed frame timing.
- locked is registered and changes on the same edge as the state transition.
- sym is never cleared except by reset.
- Counter widths are sized with clog2. There is no arithmetic overflow: all counters wrap or saturate as stated above.
- Reset mid-symbol or mid-frame discards the partial symbol; the next lock requires a fresh SYNC match in HUNT.

Test Plan:
Defaults are used throughout (W=3, SYNC=101, FRAME_SYMS=4, MAX_MISS=2), with bit_valid=1 continuously unless stated otherwise.
1. rst low 2 cycles, release, send bits 0,0,1,0,1 -> locked=0 through bit 4; locked=1 the cycle after bit 5; sym_valid stays 0.
2. After lock, send 011,100,111,000 then 101 -> sym_valid pulses 4 times with sym=3,4,7,0; sync_err never pulses; locked stays 1; sym holds 0 after the last pulse.
3. Same as 2 but the sync is 110 -> one sync_err pulse, locked=1. Next frame 4 symbols still emitted, its sync 111 -> second sync_err, locked falls the cycle after the last sync bit. Next symbols give no sym_valid until 101 reappears.
4. Repeat scenario 2 with bit_valid toggling 1,0,1,0 -> identical sym values in the same order; each sym_valid exactly one cycle wide; no change on bit_valid=0 cycles.
5. Locked mid-symbol (1 bit of a symbol received), pull rst low between edges -> locked, sym, sym_valid, sync_err all 0 before the next clk edge. After release, sending 1,1 then 0,1 gives no lock until a full 101 window with fill satisfied.
6. Override SYNC=000, reset, send bits 0 then 0 -> no lock (fill < 2). A third 0 -> locked=1 next cycle.
